// File: rtl/regfile_wb_sink_pkg.sv
// Package: regfile_wb_sink_pkg
//   Shared constants for the write-back register file and its busy-bit
//   scoreboard: default register width, default index width and the index of
//   the hard-wired zero register.
//   Build option: define REGFILE_BYPASS_EN to enable same-cycle write-through
//   from WB to the decode read ports. The default build leaves it disabled.
package regfile_wb_sink_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    // r0 is hard-wired to zero: never written, never marked busy.
    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/regfile_wb_sink_busy_scoreboard.sv
// Module: regfile_wb_sink_busy_scoreboard
//   One busy bit per architectural register, marking destinations whose
//   producer has left decode but not yet written back.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     set_en, set_idx   mark set_idx busy (issue of a writing instruction)
//     clr_en, clr_idx   clear clr_idx (write-back of that register)
//     rs_idx, rt_idx    lookup indices for the two decode read ports
//     rs_busy, rt_busy  busy state of the looked-up registers
module regfile_wb_sink_busy_scoreboard
    import regfile_wb_sink_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rs_idx,
    input  logic [ADDR_W-1:0] rt_idx,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy;
    logic            set_ok;

    // r0 can never become busy, whatever the caller passes in.
    assign set_ok = set_en && (set_idx != ADDR_W'(REG_ZERO));

    // Set has priority over clear on the same register: the issuing
    // instruction is a newer producer than the one writing back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (set_ok && (set_idx == ADDR_W'(r))) begin
                    busy[r] <= 1'b1;
                end else if (clr_en && (clr_idx == ADDR_W'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign rs_busy = busy[rs_idx];
    assign rt_busy = busy[rt_idx];

endmodule

// File: rtl/regfile_wb_sink.sv
// Module: regfile_wb_sink
//   Register file closing the pipeline loop: written by WB, read by ID through
//   two combinational ports, with a busy-bit scoreboard that stalls decode
//   while a consumed source still has a producer in flight.
//   Build option: REGFILE_BYPASS_EN (undefined by default) forwards the WB
//   value to the read ports in the write cycle and drops the stall one cycle
//   earlier.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     wb_we, wb_rd, wb_data        write-back port
//     rs_addr, rt_addr             read indices
//     rs_used, rt_used             ID instruction consumes rs / rt
//     issue_valid, issue_we,
//     issue_rd                     instruction leaving decode and its destination
//     rs_data, rt_data             read data (combinational)
//     stall                        ID must hold this cycle
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              stall
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREG];

    logic wb_write;
    logic issue_set;
    logic rs_busy;
    logic rt_busy;
    logic rs_pend;
    logic rt_pend;

    // A WB to r0 is a no-op for both the array and the read bypass.
    assign wb_write = wb_we && (wb_rd != ZERO_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Issue only takes effect when decode is not stalled; stall is built from
    // registered busy bits, so this gating forms no combinational loop.
    assign issue_set = issue_valid && issue_we && !stall;

    regfile_wb_sink_busy_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_set),
        .set_idx (issue_rd),
        .clr_en  (wb_we),
        .clr_idx (wb_rd),
        .rs_idx  (rs_addr),
        .rt_idx  (rt_addr),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy)
    );

`ifdef REGFILE_BYPASS_EN
    // The WB value is forwarded this cycle, so a source being written back
    // now is already satisfied and must not hold decode.
    assign rs_pend = rs_used && rs_busy && !(wb_we && (wb_rd == rs_addr));
    assign rt_pend = rt_used && rt_busy && !(wb_we && (wb_rd == rt_addr));

    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (wb_write && (wb_rd == rs_addr)) rs_data = wb_data;
        if (wb_write && (wb_rd == rt_addr)) rt_data = wb_data;
        if (rs_addr == ZERO_IDX) rs_data = '0;
        if (rt_addr == ZERO_IDX) rt_data = '0;
    end
`else
    // Without forwarding the new value is only visible after the edge, so
    // the busy bit alone (cleared at that edge) decides the stall.
    assign rs_pend = rs_used && rs_busy;
    assign rt_pend = rt_used && rt_busy;

    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (rs_addr == ZERO_IDX) rs_data = '0;
        if (rt_addr == ZERO_IDX) rt_data = '0;
    end
`endif

    assign stall = rs_pend || rt_pend;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Testbench: tb_regfile_wb_sink
//   Directed vectors with hand-computed expectations for regfile_wb_sink.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Expectations depend on REGFILE_BYPASS_EN where the
//   write-back cycle behaves differently.
module tb_regfile_wb_sink;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic              issue_valid;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              stall;

    int checks;
    int errors;

    regfile_wb_sink #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        wb_we       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        rs_used     = 1'b0;
        rt_used     = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic wb(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        wb_we   = 1'b1;
        wb_rd   = rd;
        wb_data = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rd);
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = rd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        idle();

        // Reset held
        next_cycle();
        rs_addr = 5'd5;
        rt_addr = 5'd3;
        sample();
        check("reset_rs", rs_data, 32'h0);
        check("reset_rt", rt_data, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Basic write then read on both ports
        wb(5'd3, 32'hDEADBEEF);
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        sample();
        check("wb_cycle_rs", rs_data, BYP ? 32'hDEADBEEF : 32'h0);
        next_cycle();
        idle();
        sample();
        check("basic_rs", rs_data, 32'hDEADBEEF);
        check("basic_rt", rt_data, 32'hDEADBEEF);

        // r0 write dropped, r0 destination never busy
        next_cycle();
        wb(5'd0, 32'hFFFFFFFF);
        rs_addr = 5'd0;
        sample();
        check("r0_wb_cycle", rs_data, 32'h0);
        next_cycle();
        idle();
        issue(5'd0);
        sample();
        check("r0_read", rs_data, 32'h0);
        next_cycle();
        idle();
        rs_used = 1'b1;
        rt_used = 1'b1;
        rt_addr = 5'd0;
        sample();
        check("r0_no_stall", {31'b0, stall}, 32'h0);

        // RAW hazard on r7
        next_cycle();
        idle();
        issue(5'd7);
        sample();
        check("raw_issue_cycle", {31'b0, stall}, 32'h0);
        next_cycle();
        idle();
        rs_addr = 5'd7;
        rs_used = 1'b1;
        sample();
        check("raw_stall_c1", {31'b0, stall}, 32'h1);
        next_cycle();
        sample();
        check("raw_stall_c2", {31'b0, stall}, 32'h1);
        next_cycle();
        wb(5'd7, 32'h55);
        sample();
        check("raw_wb_stall", {31'b0, stall}, BYP ? 32'h0 : 32'h1);
        check("raw_wb_data", rs_data, BYP ? 32'h55 : 32'h0);
        next_cycle();
        wb_we = 1'b0;
        sample();
        check("raw_after_stall", {31'b0, stall}, 32'h0);
        check("raw_after_data", rs_data, 32'h55);

        // Stall gating: issue of r9 while stalled on r8 has no effect
        next_cycle();
        idle();
        issue(5'd8);
        next_cycle();
        idle();
        rs_addr = 5'd8;
        rs_used = 1'b1;
        issue(5'd9);
        sample();
        check("gate_stalled", {31'b0, stall}, 32'h1);
        next_cycle();
        idle();
        rt_addr = 5'd9;
        rt_used = 1'b1;
        sample();
        check("gate_r9_idle", {31'b0, stall}, 32'h0);
        next_cycle();
        idle();
        rs_addr = 5'd8;
        sample();
        check("unused_busy_rs", {31'b0, stall}, 32'h0);
        next_cycle();
        wb(5'd8, 32'h88);
        next_cycle();
        idle();
        rs_used = 1'b1;
        sample();
        check("r8_cleared", {31'b0, stall}, 32'h0);
        check("r8_data", rs_data, 32'h88);

        // Set/clear collision on r4: set wins
        next_cycle();
        idle();
        issue(5'd4);
        next_cycle();
        idle();
        wb(5'd4, 32'h44);
        issue(5'd4);
        next_cycle();
        idle();
        rt_addr = 5'd4;
        rt_used = 1'b1;
        sample();
        check("collide_stall", {31'b0, stall}, 32'h1);
        check("collide_data", rt_data, 32'h44);
        next_cycle();
        wb(5'd4, 32'h45);
        next_cycle();
        wb_we = 1'b0;
        sample();
        check("collide_cleared", {31'b0, stall}, 32'h0);

        // Two in-flight writers of r10: first WB clears the single bit
        next_cycle();
        idle();
        issue(5'd10);
        next_cycle();
        issue(5'd10);
        next_cycle();
        idle();
        wb(5'd10, 32'hA0);
        next_cycle();
        idle();
        rs_addr = 5'd10;
        rs_used = 1'b1;
        sample();
        check("waw_stall", {31'b0, stall}, 32'h0);
        check("waw_data", rs_data, 32'hA0);

        // Reset mid-operation
        next_cycle();
        idle();
        wb(5'd5, 32'h1234);
        next_cycle();
        idle();
        issue(5'd6);
        next_cycle();
        idle();
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        rt_used = 1'b1;
        sample();
        check("pre_rst_r5", rs_data, 32'h1234);
        check("pre_rst_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        rt_used = 1'b0;
        wb(5'd5, 32'h99);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_r5", rs_data, 32'h0);
        rt_used = 1'b1;
        #1;
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        rst = 1'b0;
        idle();
        rt_used = 1'b1;
        sample();
        check("rst_lost_wb", rs_data, 32'h0);
        check("rst_busy_clr", {31'b0, stall}, 32'h0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
